// File: rtl/parity_sched_defs.sv
// Shared definitions for the parity check scheduler: FSM encoding and frame width.
package parity_sched_defs;

  localparam int FRAME_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/parity5_core.sv
// Five-input parity core; out1 is high when the frame has odd weight.
module parity5_core (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  output logic out1
);

  assign out1 = a ^ b ^ c ^ d ^ e;

endmodule

// File: rtl/parity_check_sched.sv
// Round-robin scheduler sharing one parity core among N_REQ requesters,
// returning a tagged response and keeping frame/error counters.
module parity_check_sched
  import parity_sched_defs::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [FRAME_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [FRAME_W-1:0]       rsp_data,
  output logic                     rsp_err,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     busy
);

  localparam int               IW1     = ID_W + 1;
  localparam logic [IW1-1:0]   N_REQ_W = IW1'(N_REQ);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [ID_W-1:0]  ID_ONE  = ID_W'(1);
  localparam logic [ID_W-1:0]  ID_ZERO = {ID_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Returns {found, index} of the first valid requester at or after ptr, wrapping.
  function automatic logic [IW1-1:0] rr_pick(
    input logic [N_REQ-1:0] v,
    input logic [ID_W-1:0]  ptr
  );
    logic [IW1-1:0]  sum;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] win;
    logic            found;
    found = 1'b0;
    win   = ID_ZERO;
    for (int i = 0; i < N_REQ; i++) begin
      sum   = {1'b0, ptr} + IW1'(i);
      idx   = (sum >= N_REQ_W) ? ID_W'(sum - N_REQ_W) : sum[ID_W-1:0];
      win   = (!found && v[idx]) ? idx : win;
      found = found | v[idx];
    end
    return {found, win};
  endfunction

  state_e           r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_cap_id;
  logic [FRAME_W-1:0] r_frame;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [FRAME_W-1:0] r_rsp_data;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_busy;

  logic             w_found;
  logic [ID_W-1:0]  w_grant;
  logic [ID_W-1:0]  w_next_ptr;
  logic [FRAME_W-1:0] w_win_frame;
  logic [N_REQ-1:0] w_req_ready;
  logic             w_xfer;
  logic             w_parity;

  // Arbitration: winner selection, its frame, and the one-hot accept strobe.
  always_comb begin
    {w_found, w_grant} = rr_pick(req_valid, r_rr_ptr);
    w_win_frame = {FRAME_W{1'b0}};
    w_req_ready = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      w_win_frame = (w_grant == ID_W'(i)) ? req_data[i*FRAME_W +: FRAME_W] : w_win_frame;
    end
    if ((r_state == IDLE) && w_found) begin
      w_req_ready[w_grant] = 1'b1;
    end else begin
      w_req_ready = {N_REQ{1'b0}};
    end
  end

  assign w_xfer     = |(req_valid & w_req_ready);
  assign w_next_ptr = (w_grant == LAST_ID) ? ID_ZERO : (w_grant + ID_ONE);

  // Frame layout is {a,b,c,d,e} with a in the MSB.
  parity5_core u_core (
    .a    (r_frame[4]),
    .b    (r_frame[3]),
    .c    (r_frame[2]),
    .d    (r_frame[1]),
    .e    (r_frame[0]),
    .out1 (w_parity)
  );

  // Scheduler FSM: accept in IDLE, evaluate and count in CHECK, hold response in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= ID_ZERO;
      r_cap_id    <= ID_ZERO;
      r_frame     <= {FRAME_W{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= ID_ZERO;
      r_rsp_data  <= {FRAME_W{1'b0}};
      r_rsp_err   <= 1'b0;
      r_frame_cnt <= {CNT_W{1'b0}};
      r_err_cnt   <= {CNT_W{1'b0}};
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_frame  <= w_win_frame;
            r_cap_id <= w_grant;
            r_rr_ptr <= w_next_ptr;
            r_state  <= CHECK;
            r_busy   <= 1'b1;
          end
        end
        CHECK: begin
          r_rsp_err   <= w_parity;
          r_rsp_data  <= r_frame;
          r_rsp_id    <= r_cap_id;
          r_frame_cnt <= r_frame_cnt + CNT_ONE;
          if (w_parity && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + CNT_ONE;
          end
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
  assign busy      = r_busy;

endmodule
